// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU operation scheduler: op codes,
// FSM states and the one-hot function-select encoding.
package alu_sched_pkg;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    // alu_sel is {mul, add, div, sub}
    localparam int SEL_BIT_MUL = 3;
    localparam int SEL_BIT_ADD = 2;
    localparam int SEL_BIT_DIV = 1;
    localparam int SEL_BIT_SUB = 0;

    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_MUL  = 4'b1000;
    localparam logic [3:0] SEL_ADD  = 4'b0100;
    localparam logic [3:0] SEL_DIV  = 4'b0010;
    localparam logic [3:0] SEL_SUB  = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [3:0] op_to_sel(input logic [1:0] op);
        logic [3:0] sel;
        case (op)
            OP_MUL:  sel = SEL_MUL;
            OP_ADD:  sel = SEL_ADD;
            OP_DIV:  sel = SEL_DIV;
            default: sel = SEL_SUB;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_iso_core.sv
// Operand-isolated 4-function arithmetic core. Each function unit only sees
// non-zero operands while its alu_sel bit is set, so idle units do not toggle.
// The selected result is registered whenever any select bit is active.
module alu_iso_core
    import alu_sched_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      alu_sel,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [2*DW-1:0] res,
    output logic            divz
);

    localparam int RW = 2 * DW;

    logic [DW-1:0] mul_a, mul_b;
    logic [DW-1:0] add_a, add_b;
    logic [DW-1:0] div_a, div_b;
    logic [DW-1:0] sub_a, sub_b;

    logic [RW-1:0] mul_y, add_y, div_y, sub_y;
    logic [RW-1:0] res_d;
    logic          div_zero;

    assign mul_a = alu_sel[SEL_BIT_MUL] ? a : '0;
    assign mul_b = alu_sel[SEL_BIT_MUL] ? b : '0;
    assign add_a = alu_sel[SEL_BIT_ADD] ? a : '0;
    assign add_b = alu_sel[SEL_BIT_ADD] ? b : '0;
    assign div_a = alu_sel[SEL_BIT_DIV] ? a : '0;
    assign div_b = alu_sel[SEL_BIT_DIV] ? b : '0;
    assign sub_a = alu_sel[SEL_BIT_SUB] ? a : '0;
    assign sub_b = alu_sel[SEL_BIT_SUB] ? b : '0;

    assign div_zero = (div_b == '0);

    // Function units: products and sums are zero-extended to the result width,
    // divide-by-zero saturates to all-ones, subtract wraps modulo 2^RW.
    always_comb begin
        mul_y = RW'(mul_a) * RW'(mul_b);
        add_y = RW'(add_a) + RW'(add_b);
        div_y = div_zero ? '1 : RW'(div_a / div_b);
        sub_y = RW'(sub_a) - RW'(sub_b);
    end

    // Output mux driven by the one-hot select.
    always_comb begin
        res_d = '0;
        case (alu_sel)
            SEL_MUL: res_d = mul_y;
            SEL_ADD: res_d = add_y;
            SEL_DIV: res_d = div_y;
            SEL_SUB: res_d = sub_y;
            default: res_d = '0;
        endcase
    end

    // Result register: loads only in the execute cycle, holds otherwise so the
    // response stays stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res  <= '0;
            divz <= 1'b0;
        end else if (|alu_sel) begin
            res  <= res_d;
            divz <= alu_sel[SEL_BIT_DIV] & div_zero;
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Round-robin arbiter and sequencer sharing one operand-isolated ALU among
// N_REQ requesters. One operation is in flight at a time.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no operation in flight; grants the round-robin winner
//   ST_EXEC | single cycle, ALU selected with captured operands
//   ST_RESP | result valid, waiting for rsp_ready; may grant on handshake
module alu_op_scheduler
    import alu_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = 4,
    parameter int ID_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [2*N_REQ-1:0]  req_op,
    input  logic [DW*N_REQ-1:0] req_a,
    input  logic [DW*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]    gnt,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2*DW-1:0]     rsp_data,
    output logic [ID_W-1:0]     rsp_id,
    output logic                rsp_divz,
    output logic [3:0]          alu_sel,
    output logic                busy
);

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [1:0]      cap_op;
    logic [DW-1:0]   cap_a;
    logic [DW-1:0]   cap_b;
    logic [ID_W-1:0] cap_id;

    logic [1:0]      op_arr [N_REQ];
    logic [DW-1:0]   a_arr  [N_REQ];
    logic [DW-1:0]   b_arr  [N_REQ];

    logic [ID_W-1:0] win_id;
    logic            win_found;
    logic [ID_W-1:0] ptr_next;
    logic            hs;
    logic            grant_en;
    logic [DW-1:0]   core_a;
    logic [DW-1:0]   core_b;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign op_arr[g] = req_op[2*g +: 2];
        assign a_arr[g]  = req_a[DW*g +: DW];
        assign b_arr[g]  = req_b[DW*g +: DW];
    end

    // Round-robin search starting at ptr, wrapping modulo N_REQ.
    always_comb begin
        logic [ID_W:0] idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(N_REQ)) begin
                idx = idx - (ID_W+1)'(N_REQ);
            end
            if (!win_found && req[idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[ID_W-1:0];
            end
        end
    end

    // Next search start is one past the winner, wrapping modulo N_REQ.
    always_comb begin
        logic [ID_W:0] nxt;
        nxt = {1'b0, win_id} + (ID_W+1)'(1);
        if (nxt >= (ID_W+1)'(N_REQ)) begin
            nxt = '0;
        end
        ptr_next = nxt[ID_W-1:0];
    end

    assign hs = rsp_valid & rsp_ready;

    // Grants happen from IDLE or on the response handshake. Gating with rst
    // keeps gnt low while reset is held even though the FSM sits in IDLE.
    assign grant_en = rst & win_found &
                      ((state == ST_IDLE) | ((state == ST_RESP) & hs));

    assign gnt = grant_en ? (N_REQ'(1) << win_id) : '0;

    // Core operands are forced to zero outside the execute cycle.
    assign core_a = (state == ST_EXEC) ? cap_a : '0;
    assign core_b = (state == ST_EXEC) ? cap_b : '0;

    // Sequencing FSM with registered select, valid, id and busy outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            cap_op    <= OP_MUL;
            cap_a     <= '0;
            cap_b     <= '0;
            cap_id    <= '0;
            alu_sel   <= SEL_NONE;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_en) begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    alu_sel   <= SEL_NONE;
                    rsp_valid <= 1'b1;
                    rsp_id    <= cap_id;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (hs) begin
                        rsp_valid <= 1'b0;
                        busy      <= grant_en;
                        state     <= grant_en ? ST_EXEC : ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    alu_sel <= SEL_NONE;
                    busy    <= 1'b0;
                end
            endcase

            if (grant_en) begin
                cap_op  <= op_arr[win_id];
                cap_a   <= a_arr[win_id];
                cap_b   <= b_arr[win_id];
                cap_id  <= win_id;
                alu_sel <= op_to_sel(op_arr[win_id]);
                ptr     <= ptr_next;
                busy    <= 1'b1;
            end
        end
    end

    alu_iso_core #(
        .DW (DW)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .alu_sel (alu_sel),
        .a       (core_a),
        .b       (core_b),
        .res     (rsp_data),
        .divz    (rsp_divz)
    );

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_alu_op_scheduler;

    localparam int N_REQ = 4;
    localparam int DW    = 4;
    localparam int ID_W  = 2;

    localparam logic [1:0] MUL = 2'b00;
    localparam logic [1:0] ADD = 2'b01;
    localparam logic [1:0] DIV = 2'b10;
    localparam logic [1:0] SUB = 2'b11;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_REQ-1:0]    req;
    logic [2*N_REQ-1:0]  req_op;
    logic [DW*N_REQ-1:0] req_a;
    logic [DW*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]    gnt;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [2*DW-1:0]     rsp_data;
    logic [ID_W-1:0]     rsp_id;
    logic                rsp_divz;
    logic [3:0]          alu_sel;
    logic                busy;

    logic [1:0]    op_l [N_REQ];
    logic [DW-1:0] a_l  [N_REQ];
    logic [DW-1:0] b_l  [N_REQ];

    assign req_op = {op_l[3], op_l[2], op_l[1], op_l[0]};
    assign req_a  = {a_l[3], a_l[2], a_l[1], a_l[0]};
    assign req_b  = {b_l[3], b_l[2], b_l[1], b_l[0]};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_op_scheduler #(
        .N_REQ (N_REQ),
        .DW    (DW),
        .ID_W  (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_divz  (rsp_divz),
        .alu_sel   (alu_sel),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] sel_of(input logic [1:0] op);
        logic [3:0] s;
        s = 4'b1000 >> op;
        return s;
    endfunction

    task automatic set_lanes(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        for (int i = 0; i < N_REQ; i++) begin
            op_l[i] = op;
            a_l[i]  = a;
            b_l[i]  = b;
        end
    endtask

    // Entered and left 1 unit after a rising edge with the DUT idle.
    task automatic run_op(input logic [3:0] mask, input logic [1:0] op,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] exp_gnt, input logic [1:0] exp_id,
                          input logic [7:0] exp_data, input logic exp_divz);
        set_lanes(op, a, b);
        req = mask;
        @(negedge clk);
        chk("idle_gnt", 32'(gnt), 32'(exp_gnt));
        chk("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        chk("exec_sel", 32'(alu_sel), 32'(sel_of(op)));
        chk("exec_gnt", 32'(gnt), 32'd0);
        chk("exec_valid", 32'(rsp_valid), 32'd0);
        chk("exec_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("resp_valid", 32'(rsp_valid), 32'd1);
        chk("resp_data", 32'(rsp_data), 32'(exp_data));
        chk("resp_id", 32'(rsp_id), 32'(exp_id));
        chk("resp_divz", 32'(rsp_divz), 32'(exp_divz));
        chk("resp_sel", 32'(alu_sel), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_valid", 32'(rsp_valid), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        req       = '0;
        rsp_ready = 1'b1;
        set_lanes(MUL, 4'd0, 4'd0);

        // Reset held with random requests: everything stays quiet.
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            req = 4'($urandom_range(1, 15));
            @(negedge clk);
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_valid", 32'(rsp_valid), 32'd0);
            chk("rst_sel", 32'(alu_sel), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_data", 32'(rsp_data), 32'd0);
            chk("rst_id", 32'(rsp_id), 32'd0);
            chk("rst_divz", 32'(rsp_divz), 32'd0);
        end
        @(posedge clk); #1;
        req = '0;
        rst = 1'b1;
        @(posedge clk); #1;

        // Pointer starts at requester 0: all requesting -> 0 wins.
        run_op(4'b1111, MUL, 4'd7, 4'd9, 4'b0001, 2'd0, 8'd63, 1'b0);
        // Single requester 0, MUL 7*9.
        run_op(4'b0001, MUL, 4'd7, 4'd9, 4'b0001, 2'd0, 8'd63, 1'b0);
        // Requester 2: divide by zero, then subtract with wrap.
        run_op(4'b0100, DIV, 4'd5, 4'd0, 4'b0100, 2'd2, 8'hFF, 1'b1);
        run_op(4'b0100, SUB, 4'd3, 4'd5, 4'b0100, 2'd2, 8'hFE, 1'b0);
        run_op(4'b0100, DIV, 4'd13, 4'd4, 4'b0100, 2'd2, 8'd3, 1'b0);
        // Requester 3 leaves the pointer at 0 for the back-to-back run.
        run_op(4'b1000, MUL, 4'd15, 4'd15, 4'b1000, 2'd3, 8'd225, 1'b0);

        // All four requesting, rsp_ready high: grants 0,1,2,3,0.
        set_lanes(ADD, 4'd15, 4'd15);
        req = 4'b1111;
        @(negedge clk);
        chk("rr_gnt0", 32'(gnt), 32'b0001);
        chk("rr_idle_core_a", 32'(dut.core_a), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k == 4) req = '0;
            @(negedge clk);
            chk("rr_exec_gnt", 32'(gnt), 32'd0);
            chk("rr_exec_sel", 32'(alu_sel), 32'b0100);
            chk("rr_exec_core_a", 32'(dut.core_a), 32'd15);
            @(posedge clk); #1;
            @(negedge clk);
            chk("rr_valid", 32'(rsp_valid), 32'd1);
            chk("rr_id", 32'(rsp_id), 32'(k % 4));
            chk("rr_data", 32'(rsp_data), 32'd30);
            chk("rr_resp_core_a", 32'(dut.core_a), 32'd0);
            chk("rr_resp_core_b", 32'(dut.core_b), 32'd0);
            chk("rr_gnt", 32'(gnt), (k < 4) ? 32'(4'b0001 << ((k + 1) % 4)) : 32'd0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("rr_end_valid", 32'(rsp_valid), 32'd0);
        chk("rr_end_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Backpressure: requester 1 MUL 3*4 while requester 3 waits.
        rsp_ready = 1'b0;
        op_l[1] = MUL; a_l[1] = 4'd3; b_l[1] = 4'd4;
        op_l[3] = SUB; a_l[3] = 4'd9; b_l[3] = 4'd2;
        req = 4'b0010;
        @(negedge clk);
        chk("bp_gnt1", 32'(gnt), 32'b0010);
        @(posedge clk); #1;
        req = 4'b1000;
        @(negedge clk);
        chk("bp_exec_gnt", 32'(gnt), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", 32'(rsp_data), 32'd12);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_gnt", 32'(gnt), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_gnt", 32'(gnt), 32'b1000);
        chk("bp_hs_data", 32'(rsp_data), 32'd12);
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        chk("bp_exec_sel", 32'(alu_sel), 32'b0001);
        chk("bp_exec_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_sub_data", 32'(rsp_data), 32'd7);
        chk("bp_sub_id", 32'(rsp_id), 32'd3);
        chk("bp_sub_divz", 32'(rsp_divz), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset asserted during EXEC discards the operation.
        set_lanes(ADD, 4'd1, 4'd2);
        req = 4'b0001;
        @(negedge clk);
        chk("mr_gnt", 32'(gnt), 32'b0001);
        @(posedge clk); #1;
        req = '0;
        rst = 1'b0;
        @(negedge clk);
        chk("mr_sel", 32'(alu_sel), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_valid", 32'(rsp_valid), 32'd0);
        chk("mr_data", 32'(rsp_data), 32'd0);
        chk("mr_id", 32'(rsp_id), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mr_post_valid", 32'(rsp_valid), 32'd0);
            chk("mr_post_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
